// File: rtl/edge_pack.sv
// -----------------------------------------------------------------------------
// edge_pack
//
// Packs the 1-bit edge stream from the Sobel stage into 16-bit words for the
// SDRAM write path. The earliest pixel of a word lands in bit 0. Frame
// start/end markers travel with the word that holds the first/last pixel.
// Each frame's pixel count is compared with IMG_W*IMG_H, and frm_err pulses
// on a length mismatch or a framing error.
//
// Optional feature (macro EDGE_CNT_EN): when defined, edge_cnt reports the
// number of din=1 pixels in the last completed frame. When undefined, there
// is no counter logic and edge_cnt is tied to 0.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   din       in   binary edge pixel (1 = edge)
//   din_sop   in   first pixel of frame (qualified by din_vld)
//   din_eop   in   last pixel of frame (qualified by din_vld)
//   din_vld   in   pixel valid
//   dout      out  packed word, bit0 = earliest pixel
//   dout_sop  out  word contains the frame's first pixel
//   dout_eop  out  word contains the frame's last pixel
//   dout_vld  out  single-cycle word valid pulse
//   frm_err   out  single-cycle frame length / framing error pulse
//   edge_cnt  out  edge-pixel count of the last completed frame
// -----------------------------------------------------------------------------
module edge_pack #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          din_sop,
    input  logic          din_eop,
    input  logic          din_vld,
    output logic [DW-1:0] dout,
    output logic          dout_sop,
    output logic          dout_eop,
    output logic          dout_vld,
    output logic          frm_err,
    output logic [19:0]   edge_cnt
);

    localparam logic [18:0] FRAME_LEN = 19'(IMG_W * IMG_H);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PACK = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [DW-1:0] sreg_q, sreg_d;
    logic          sop_pend_q, sop_pend_d;
    logic [18:0]   pix_cnt_q, pix_cnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_sop_q, dout_sop_d;
    logic          dout_eop_q, dout_eop_d;
    logic          dout_vld_q, dout_vld_d;
    logic          frm_err_q, frm_err_d;

    logic [DW-1:0] wr_word_s;
    logic [18:0]   cnt_inc_s;

    // Current shift register with the incoming pixel merged at idx; count + 1 (saturating)
    always_comb begin
        wr_word_s        = sreg_q;
        wr_word_s[idx_q] = din;
        if (pix_cnt_q == {19{1'b1}}) begin
            cnt_inc_s = pix_cnt_q;
        end else begin
            cnt_inc_s = pix_cnt_q + 19'd1;
        end
    end

    // Next-state and output decode for the packer FSM.
    // The shift register is cleared whenever a word is emitted or a frame
    // starts, so bits above idx are always 0 and a partial eop word needs
    // no further masking.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sreg_d     = sreg_q;
        sop_pend_d = sop_pend_q;
        pix_cnt_d  = pix_cnt_q;
        dout_d     = dout_q;
        dout_sop_d = 1'b0;
        dout_eop_d = 1'b0;
        dout_vld_d = 1'b0;
        frm_err_d  = 1'b0;

        if (!din_vld) begin
            // Gap cycle: hold all state.
            state_d = state_q;
        end else if (din_sop) begin
            // sop seen while packing aborts the partial frame without emitting it.
            frm_err_d = (state_q == ST_PACK);
            if (din_eop) begin
                // One-pixel frame: emit immediately, stay idle.
                dout_d     = {{(DW-1){1'b0}}, din};
                dout_vld_d = 1'b1;
                dout_sop_d = 1'b1;
                dout_eop_d = 1'b1;
                frm_err_d  = (state_q == ST_PACK) || (FRAME_LEN != 19'd1);
                sreg_d     = {DW{1'b0}};
                idx_d      = 4'd0;
                pix_cnt_d  = 19'd0;
                sop_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end else begin
                sreg_d     = {{(DW-1){1'b0}}, din};
                idx_d      = 4'd1;
                pix_cnt_d  = 19'd1;
                sop_pend_d = 1'b1;
                state_d    = ST_PACK;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Pixels outside a frame are dropped; a stray eop is a framing error.
                    frm_err_d = din_eop;
                end
                ST_PACK: begin
                    if (din_eop) begin
                        dout_d     = wr_word_s;
                        dout_vld_d = 1'b1;
                        dout_sop_d = sop_pend_q;
                        dout_eop_d = 1'b1;
                        frm_err_d  = (cnt_inc_s != FRAME_LEN);
                        sreg_d     = {DW{1'b0}};
                        idx_d      = 4'd0;
                        pix_cnt_d  = 19'd0;
                        sop_pend_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else if (idx_q == 4'd15) begin
                        dout_d     = wr_word_s;
                        dout_vld_d = 1'b1;
                        dout_sop_d = sop_pend_q;
                        sreg_d     = {DW{1'b0}};
                        idx_d      = 4'd0;
                        pix_cnt_d  = cnt_inc_s;
                        sop_pend_d = 1'b0;
                    end else begin
                        sreg_d    = wr_word_s;
                        idx_d     = idx_q + 4'd1;
                        pix_cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Packer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            sreg_q     <= {DW{1'b0}};
            sop_pend_q <= 1'b0;
            pix_cnt_q  <= 19'd0;
            dout_q     <= {DW{1'b0}};
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            dout_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sreg_q     <= sreg_d;
            sop_pend_q <= sop_pend_d;
            pix_cnt_q  <= pix_cnt_d;
            dout_q     <= dout_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
            dout_vld_q <= dout_vld_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign dout     = dout_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;
    assign dout_vld = dout_vld_q;
    assign frm_err  = frm_err_q;

`ifdef EDGE_CNT_EN
    logic        pix_take_s;
    logic        frm_end_s;
    logic [19:0] acc_nxt_s;
    logic [19:0] edge_acc_q, edge_acc_d;
    logic [19:0] edge_cnt_q, edge_cnt_d;

    // A pixel belongs to a frame when it starts one or arrives while packing.
    assign pix_take_s = din_vld && (din_sop || (state_q == ST_PACK));
    assign frm_end_s  = pix_take_s && din_eop;

    // Running edge count; sop restarts it, so an aborted frame never reaches edge_cnt
    always_comb begin
        if (din_sop) begin
            acc_nxt_s = {19'd0, din};
        end else begin
            acc_nxt_s = edge_acc_q + {19'd0, din};
        end
        if (pix_take_s) begin
            edge_acc_d = acc_nxt_s;
        end else begin
            edge_acc_d = edge_acc_q;
        end
        if (frm_end_s) begin
            edge_cnt_d = acc_nxt_s;
        end else begin
            edge_cnt_d = edge_cnt_q;
        end
    end

    // Edge accumulator and last-frame result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_acc_q <= 20'd0;
            edge_cnt_q <= 20'd0;
        end else begin
            edge_acc_q <= edge_acc_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`else
    assign edge_cnt = 20'd0;
`endif

endmodule
